regfile_port_ctrl: RTL
======================

Name: regfile_port_ctrl

Overview:
- Sits directly upstream of the 16x32 register file and owns its single available/busy handshake port.
- Arbitrates between a writeback client and an operand-read client; writeback has priority.
- Sequences each access through the register file's multi-cycle protocol and buffers read operands for the execute stage behind a valid/ready output.
- Short-circuits reads of r0/r0 and runs a watchdog on the register file handshake.

Parameters:
TIMEOUT, 15, maximum cycles spent in REQ or WAIT before an access is aborted (must be >= 4)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
wb_valid  in  1  write request present
wb_ready  out  1  write request accepted this cycle when wb_valid=1
wb_addr  in  4  destination register
wb_data  in  32  data to write
wb_done  out  1  one-cycle pulse when the write has completed
rd_valid  in  1  operand read request present
rd_ready  out  1  read request accepted this cycle when rd_valid=1
rd_rs1  in  4  source register A
rd_rs2  in  4  source register B
op_valid  out  1  operands available
op_ready  in  1  execute stage consumes operands
op_a  out  32  operand A
op_b  out  32  operand B
rf_available  out  1  register file operation available
rf_write_en  out  1  register file write select
rf_write_addr  out  4  register file write address
rf_write_data  out  32  register file write data
rf_read_addr_a  out  4  register file read address A
rf_read_addr_b  out  4  register file read address B
rf_read_data_a  in  32  register file read data A
rf_read_data_b  in  32  register file read data B
rf_busy  in  1  register file busy
err  out  1  sticky watchdog error

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; rf_available, rf_write_en, wb_done, op_valid, and err = 0; op_a, op_b, and all rf address/data outputs = 0.
- States: IDLE, REQ, WAIT, RELEASE.
- wb_ready = (state==IDLE). rd_ready = (state==IDLE) & ~wb_valid & (~op_valid | op_ready).
- Accepting a request latches its fields into rf_* registers, which stay stable until RELEASE.
- Write accept: rf_write_en=1, rf_write_addr=wb_addr, rf_write_data=wb_data; go to REQ.
- Read accept with rd_rs1 != 0 or rd_rs2 != 0: rf_write_en=0, rf_read_addr_a/b latched; go to REQ.
- Read accept with rd_rs1 == rd_rs2 == 0: no register file access; next cycle op_valid=1 and op_a = op_b = 0; state stays IDLE.
- REQ: rf_available=1. rf_busy=1 -> WAIT.
- WAIT: rf_available=1. rf_busy=0 -> RELEASE. For a read, op_a and op_b are loaded from rf_read_data_a/b on this same edge, and op_valid=1 from the next cycle.
- RELEASE: rf_available=0 for exactly one cycle; wb_done=1 if the access was a write; then -> IDLE. This guarantees the register file returns to idle before the next request.
- rf_available never rises in the cycle immediately after RELEASE (IDLE always intervenes). Minimum request spacing is 5 cycles.
- op_valid holds with op_a/op_b stable until op_valid & op_ready; it clears the next cycle unless a zero-read completes in the same cycle.
- A write may be accepted and completed while op_valid is pending; op_a/op_b are not disturbed.
- Simultaneous wb_valid and rd_valid in IDLE: the write is accepted, and the read waits with rd_ready=0.
- Watchdog: a counter resets on entry to REQ and increments in REQ and WAIT. When it reaches TIMEOUT: err=1 (sticky until reset), go to RELEASE, and no wb_done or op_valid is produced for that access.
- Reset mid-operation returns to IDLE immediately and discards latched requests and buffered operands. The register file shares reset_n.

Test Plan:
- Reset, then write wb_addr=3, wb_data=0xDEADBEEF accepted at cycle 0 -> rf_available=1 in cycles 1-3, wb_done pulse at cycle 4, and register file r3 = 0xDEADBEEF.
- After that write, read rs1=3, rs2=0 accepted at cycle 0 -> op_valid=1 at cycle 5 with op_a=0xDEADBEEF, op_b=0; op_ready held low for 3 cycles -> values stable and rd_ready=0.
- Same-cycle wb_valid (addr 5, 0x12345678) and rd_valid (rs1=5, rs2=5) -> write accepted first, read accepted after wb_done; op_a = op_b = 0x12345678.
- Read rs1=0, rs2=0 -> op_valid the next cycle with zero operands, and rf_available never asserted.
- Register file stub holds rf_busy=0 forever -> err=1 after TIMEOUT=15 cycles in REQ, rf_available drops, and no op_valid or wb_done is produced.
- reset_n=0 during WAIT of a read -> next cycle state IDLE, rf_available=0, op_valid=0; a subsequent write completes normally.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// Owns the single available/busy handshake port of the 16x32 register file.
// Arbitrates writeback over operand reads and buffers read operands for execute.
module regfile_port_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [3:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        wb_done,
   input  logic        rd_valid,
   output logic        rd_ready,
   input  logic [3:0]  rd_rs1,
   input  logic [3:0]  rd_rs2,
   output logic        op_valid,
   input  logic        op_ready,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic        rf_available,
   output logic        rf_write_en,
   output logic [3:0]  rf_write_addr,
   output logic [31:0] rf_write_data,
   output logic [3:0]  rf_read_addr_a,
   output logic [3:0]  rf_read_addr_b,
   input  logic [31:0] rf_read_data_a,
   input  logic [31:0] rf_read_data_b,
   input  logic        rf_busy,
   output logic        err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RELEASE
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] wd_cnt_reg;
   logic          is_write_reg;
   logic          aborted_reg;
   logic          err_reg;
   logic          op_valid_reg;
   logic [31:0]   op_a_reg, op_b_reg;
   logic          rf_write_en_reg;
   logic [3:0]    rf_write_addr_reg;
   logic [31:0]   rf_write_data_reg;
   logic [3:0]    rf_read_addr_a_reg, rf_read_addr_b_reg;

   logic          wb_accept;
   logic          rd_accept;
   logic          zero_read;
   logic          timeout;
   logic          load_ops;
   logic          release_read;

   always_comb begin
      state_next   = state_reg;
      wb_ready     = 1'b0;
      rd_ready     = 1'b0;
      wb_accept    = 1'b0;
      rd_accept    = 1'b0;
      zero_read    = 1'b0;
      timeout      = 1'b0;
      load_ops     = 1'b0;
      release_read = 1'b0;
      rf_available = 1'b0;
      wb_done      = 1'b0;
      case (state_reg)
         S_IDLE: begin
            wb_ready = 1'b1;
            rd_ready = ~wb_valid & (~op_valid_reg | op_ready);
            if (wb_valid) begin
               wb_accept  = 1'b1;
               state_next = S_REQ;
            end else if (rd_valid && rd_ready) begin
               if ((rd_rs1 != 4'd0) || (rd_rs2 != 4'd0)) begin
                  rd_accept  = 1'b1;
                  state_next = S_REQ;
               end else begin
                  // r0/r0 is always zero: answer without touching the register file
                  zero_read = 1'b1;
               end
            end
         end
         S_REQ: begin
            rf_available = 1'b1;
            if (wd_cnt_reg == CW'(TIMEOUT - 1)) begin
               timeout    = 1'b1;
               state_next = S_RELEASE;
            end else if (rf_busy) begin
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            rf_available = 1'b1;
            if (wd_cnt_reg == CW'(TIMEOUT - 1)) begin
               timeout    = 1'b1;
               state_next = S_RELEASE;
            end else if (!rf_busy) begin
               load_ops   = ~is_write_reg;
               state_next = S_RELEASE;
            end
         end
         S_RELEASE: begin
            wb_done      = is_write_reg & ~aborted_reg;
            release_read = ~is_write_reg & ~aborted_reg;
            state_next   = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg          <= S_IDLE;
         wd_cnt_reg         <= '0;
         is_write_reg       <= 1'b0;
         aborted_reg        <= 1'b0;
         err_reg            <= 1'b0;
         op_valid_reg       <= 1'b0;
         op_a_reg           <= '0;
         op_b_reg           <= '0;
         rf_write_en_reg    <= 1'b0;
         rf_write_addr_reg  <= '0;
         rf_write_data_reg  <= '0;
         rf_read_addr_a_reg <= '0;
         rf_read_addr_b_reg <= '0;
      end else begin
         state_reg <= state_next;

         if (wb_accept || rd_accept) begin
            wd_cnt_reg <= '0;
         end else if (state_reg == S_REQ || state_reg == S_WAIT) begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
         end

         if (wb_accept) begin
            is_write_reg      <= 1'b1;
            aborted_reg       <= 1'b0;
            rf_write_en_reg   <= 1'b1;
            rf_write_addr_reg <= wb_addr;
            rf_write_data_reg <= wb_data;
         end else if (rd_accept) begin
            is_write_reg       <= 1'b0;
            aborted_reg        <= 1'b0;
            rf_write_en_reg    <= 1'b0;
            rf_read_addr_a_reg <= rd_rs1;
            rf_read_addr_b_reg <= rd_rs2;
         end

         if (timeout) begin
            err_reg     <= 1'b1;
            aborted_reg <= 1'b1;
         end

         if (load_ops) begin
            op_a_reg <= rf_read_data_a;
            op_b_reg <= rf_read_data_b;
         end

         // A zero-read completing in the same cycle as a consume keeps op_valid high
         if (zero_read) begin
            op_valid_reg <= 1'b1;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
         end else if (release_read) begin
            op_valid_reg <= 1'b1;
         end else if (op_valid_reg && op_ready) begin
            op_valid_reg <= 1'b0;
         end
      end
   end

   assign op_valid       = op_valid_reg;
   assign op_a           = op_a_reg;
   assign op_b           = op_b_reg;
   assign err            = err_reg;
   assign rf_write_en    = rf_write_en_reg;
   assign rf_write_addr  = rf_write_addr_reg;
   assign rf_write_data  = rf_write_data_reg;
   assign rf_read_addr_a = rf_read_addr_a_reg;
   assign rf_read_addr_b = rf_read_addr_b_reg;

endmodule
